cpu_selftest_ctrl: RTL and testbench

//  Parametrised on-chip run-and-check controller for PipelinedCPU. On start it holds the

---
 rtl/cpu_selftest_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_selftest_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_selftest_ctrl.sv
// Run-and-check controller for PipelinedCPU: resets the core, runs it for a bounded
// window, then reads back architectural registers and scores them against a fixed table.
module cpu_selftest_ctrl #(
  parameter int unsigned                 XLEN         = 32,
  parameter int unsigned                 NUM_CHECKS   = 3,
  parameter logic [NUM_CHECKS*5-1:0]     CHK_ADDRS    = {5'd3, 5'd2, 5'd1},
  parameter logic [NUM_CHECKS*XLEN-1:0]  CHK_VALS     = {32'd30, 32'd20, 32'd10},
  parameter int unsigned                 RESET_CYCLES = 2,
  parameter int unsigned                 MAX_CYCLES   = 10,
  parameter bit                          HALT_EN      = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                cpu_halt_i,
  input  logic [XLEN-1:0]                     cpu_pc_i,
  input  logic [XLEN-1:0]                     dbg_rdata_i,
  output logic                                cpu_rst_o,
  output logic [4:0]                          dbg_raddr_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                pass_o,
  output logic                                timeout_o,
  output logic [$clog2(NUM_CHECKS+1)-1:0]     fail_count_o,
  output logic [$clog2(NUM_CHECKS):0]         first_fail_idx_o,
  output logic [XLEN-1:0]                     first_fail_data_o,
  output logic [31:0]                         run_cycles_o,
  output logic [XLEN-1:0]                     final_pc_o
);

  localparam int unsigned FC_W  = $clog2(NUM_CHECKS + 1);
  localparam int unsigned FF_W  = $clog2(NUM_CHECKS) + 1;
  localparam int unsigned IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int unsigned RC_W  = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_ISSUE,
    S_CMP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [IDX_W-1:0]  chk_idx_q, chk_idx_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [4:0]        dbg_raddr_q, dbg_raddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [FC_W-1:0]   fail_count_q, fail_count_d;
  logic [FF_W-1:0]   ff_idx_q, ff_idx_d;
  logic [XLEN-1:0]   ff_data_q, ff_data_d;
  logic [31:0]       run_cycles_q, run_cycles_d;
  logic [XLEN-1:0]   final_pc_q, final_pc_d;

  logic [4:0]        exp_addr;
  logic [XLEN-1:0]   exp_val;
  logic [31:0]       run_next;
  logic              budget_end;
  logic              halt_hit;
  logic              mismatch;

  assign run_next   = run_cycles_q + 32'd1;
  assign budget_end = (run_next == 32'(MAX_CYCLES));
  assign halt_hit   = HALT_EN && cpu_halt_i;
  assign mismatch   = (dbg_rdata_i != exp_val);

  // Table lookup for the entry currently being issued/compared
  always_comb begin
    exp_addr = '0;
    exp_val  = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (IDX_W'(i) == chk_idx_q) begin
        exp_addr = CHK_ADDRS[5*i +: 5];
        exp_val  = CHK_VALS[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    chk_idx_d    = chk_idx_q;
    cpu_rst_d    = cpu_rst_q;
    dbg_raddr_d  = dbg_raddr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    fail_count_d = fail_count_q;
    ff_idx_d     = ff_idx_q;
    ff_data_d    = ff_data_q;
    run_cycles_d = run_cycles_q;
    final_pc_d   = final_pc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_RESET;
          rst_cnt_d    = '0;
          chk_idx_d    = '0;
          cpu_rst_d    = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          fail_count_d = '0;
          ff_idx_d     = '1;
          ff_data_d    = '0;
          run_cycles_d = '0;
          final_pc_d   = '0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        run_cycles_d = run_next;
        if (halt_hit || budget_end) begin
          final_pc_d = cpu_pc_i;
          // A halt landing on the last budget cycle still counts as a clean stop
          if (HALT_EN && !halt_hit) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        dbg_raddr_d = exp_addr;
        state_d     = S_CMP;
      end
      S_CMP: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + FC_W'(1);
          if (fail_count_q == '0) begin
            ff_idx_d  = FF_W'(chk_idx_q);
            ff_data_d = dbg_rdata_i;
          end
        end
        if (chk_idx_q == IDX_W'(NUM_CHECKS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = !mismatch && (fail_count_q == '0);
        end else begin
          chk_idx_d = chk_idx_q + IDX_W'(1);
          state_d   = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      chk_idx_q    <= '0;
      cpu_rst_q    <= 1'b1;
      dbg_raddr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_count_q <= '0;
      ff_idx_q     <= '1;
      ff_data_q    <= '0;
      run_cycles_q <= '0;
      final_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      chk_idx_q    <= chk_idx_d;
      cpu_rst_q    <= cpu_rst_d;
      dbg_raddr_q  <= dbg_raddr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      fail_count_q <= fail_count_d;
      ff_idx_q     <= ff_idx_d;
      ff_data_q    <= ff_data_d;
      run_cycles_q <= run_cycles_d;
      final_pc_q   <= final_pc_d;
    end
  end

  assign cpu_rst_o         = cpu_rst_q;
  assign dbg_raddr_o       = dbg_raddr_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign timeout_o         = timeout_q;
  assign fail_count_o      = fail_count_q;
  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_data_o = ff_data_q;
  assign run_cycles_o      = run_cycles_q;
  assign final_pc_o        = final_pc_q;

endmodule

// File: tb/tb_cpu_selftest_ctrl.sv
// Bench for cpu_selftest_ctrl: one instance with defaults, one with HALT_EN=1,
// each scored every cycle against a phase-counting reference model.
module tb_cpu_selftest_ctrl;

  localparam int R    = 2;
  localparam int MAXC = 10;
  localparam int N    = 3;
  localparam int CA [N] = '{1, 2, 3};
  localparam int CV [N] = '{10, 20, 30};

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1, halt0, halt1;
  logic [31:0] pc;

  logic        cpu_rst_w [2];
  logic [4:0]  raddr_w   [2];
  logic [31:0] rdata_w   [2];
  logic        busy_w    [2];
  logic        done_w    [2];
  logic        pass_w    [2];
  logic        to_w      [2];
  logic [1:0]  fcnt_w    [2];
  logic [2:0]  ffi_w     [2];
  logic [31:0] ffd_w     [2];
  logic [31:0] runc_w    [2];
  logic [31:0] fpc_w     [2];

  logic [31:0] regs [2][32];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign rdata_w[0] = regs[0][raddr_w[0]];
  assign rdata_w[1] = regs[1][raddr_w[1]];

  cpu_selftest_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .cpu_halt_i(halt0),
    .cpu_pc_i(pc), .dbg_rdata_i(rdata_w[0]),
    .cpu_rst_o(cpu_rst_w[0]), .dbg_raddr_o(raddr_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .pass_o(pass_w[0]), .timeout_o(to_w[0]),
    .fail_count_o(fcnt_w[0]), .first_fail_idx_o(ffi_w[0]),
    .first_fail_data_o(ffd_w[0]), .run_cycles_o(runc_w[0]), .final_pc_o(fpc_w[0])
  );

  cpu_selftest_ctrl #(.HALT_EN(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .cpu_halt_i(halt1),
    .cpu_pc_i(pc), .dbg_rdata_i(rdata_w[1]),
    .cpu_rst_o(cpu_rst_w[1]), .dbg_raddr_o(raddr_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .pass_o(pass_w[1]), .timeout_o(to_w[1]),
    .fail_count_o(fcnt_w[1]), .first_fail_idx_o(ffi_w[1]),
    .first_fail_data_o(ffd_w[1]), .run_cycles_o(runc_w[1]), .final_pc_o(fpc_w[1])
  );

  typedef struct {
    logic        cpu_rst;
    logic [4:0]  raddr;
    logic        busy, done, pass, timeout;
    logic [1:0]  fcnt;
    logic [2:0]  ffi;
    logic [31:0] ffd, runc, fpc;
  } exp_t;

  exp_t exp_q [2];
  bit   act   [2];
  int   tt    [2];
  int   ll    [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset(input int k);
    exp_q[k] = '{cpu_rst: 1'b1, raddr: 5'd0, busy: 1'b0, done: 1'b0, pass: 1'b0,
                 timeout: 1'b0, fcnt: 2'd0, ffi: 3'b111, ffd: 32'd0, runc: 32'd0, fpc: 32'd0};
    act[k] = 1'b0;
  endtask

  // tt counts edges since the accepting edge; ll is the run length once known
  task automatic model_step(input int k, input logic st, input logic hl);
    exp_t e;
    int   c, idx;
    bit   hit;
    e = exp_q[k];
    if (!act[k]) begin
      if (st) begin
        e.cpu_rst = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.pass = 1'b0; e.timeout = 1'b0;
        e.fcnt = 2'd0; e.ffi = 3'b111; e.ffd = 32'd0; e.runc = 32'd0; e.fpc = 32'd0;
        act[k] = 1'b1; tt[k] = 0; ll[k] = 0;
      end
    end else begin
      tt[k]++;
      if (tt[k] == R) begin
        e.cpu_rst = 1'b0;
      end else if (tt[k] > R) begin
        if (ll[k] == 0) begin
          e.runc = 32'(tt[k] - R);
          hit = (k == 1) && hl;
          if ((tt[k] - R) == MAXC || hit) begin
            e.fpc = pc;
            ll[k] = tt[k] - R;
            if (k == 1 && !hit) begin
              e.timeout = 1'b1; e.done = 1'b1; e.busy = 1'b0; act[k] = 1'b0;
            end
          end
        end else begin
          c = tt[k] - R - ll[k];
          if (c % 2 == 1) begin
            e.raddr = 5'(CA[(c - 1) / 2]);
          end else begin
            idx = c / 2 - 1;
            if (regs[k][CA[idx]] != 32'(CV[idx])) begin
              if (e.fcnt == 2'd0) begin
                e.ffi = 3'(idx);
                e.ffd = regs[k][CA[idx]];
              end
              e.fcnt = e.fcnt + 2'd1;
            end
            if (c == 2 * N) begin
              e.done = 1'b1; e.busy = 1'b0; e.pass = (e.fcnt == 2'd0); act[k] = 1'b0;
            end
          end
        end
      end
    end
    exp_q[k] = e;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, start0, halt0);
      model_step(1, start1, halt1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.cpu_rst", k),   32'(cpu_rst_w[k]), 32'(exp_q[k].cpu_rst));
        chk($sformatf("u%0d.dbg_raddr", k), 32'(raddr_w[k]),   32'(exp_q[k].raddr));
        chk($sformatf("u%0d.busy", k),      32'(busy_w[k]),    32'(exp_q[k].busy));
        chk($sformatf("u%0d.done", k),      32'(done_w[k]),    32'(exp_q[k].done));
        chk($sformatf("u%0d.pass", k),      32'(pass_w[k]),    32'(exp_q[k].pass));
        chk($sformatf("u%0d.timeout", k),   32'(to_w[k]),      32'(exp_q[k].timeout));
        chk($sformatf("u%0d.fail_count", k), 32'(fcnt_w[k]),   32'(exp_q[k].fcnt));
        chk($sformatf("u%0d.ff_idx", k),    32'(ffi_w[k]),     32'(exp_q[k].ffi));
        chk($sformatf("u%0d.ff_data", k),   ffd_w[k],          exp_q[k].ffd);
        chk($sformatf("u%0d.run_cycles", k), runc_w[k],        exp_q[k].runc);
        chk($sformatf("u%0d.final_pc", k),  fpc_w[k],          exp_q[k].fpc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
  endtask

  task automatic wait_done(input int k, input int n0, output int n, output int hi);
    n  = n0;
    hi = 0;
    while (!done_w[k] && n < 100) begin
      tick();
      n++;
      if (cpu_rst_w[k]) hi++;
    end
    chk($sformatf("u%0d.wait_done", k), 32'(done_w[k]), 32'd1);
  endtask

  // Start on instance k; hold keeps start high until done shows
  task automatic run_to_done(input int k, input bit hold, output int n, output int hi);
    int h0;
    if (k == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    h0 = cpu_rst_w[k] ? 1 : 0;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    wait_done(k, 1, n, hi);
    hi = hi + h0;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi;
    logic [31:0] hpc;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; halt0 = 1'b0; halt1 = 1'b0;
    pc  = 32'h0000_1000;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) regs[k][r] = 32'(r * 10);
    tick(); tick();
    chk_en = 1'b1;
    chk("reset.cpu_rst", 32'(cpu_rst_w[0]), 32'd1);
    chk("reset.ff_idx",  32'(ffi_w[0]),     32'd7);
    chk("reset.done",    32'(done_w[0]),    32'd0);
    rst = 1'b0;
    tick();

    // Defaults: halt is asserted throughout but must be ignored
    halt0 = 1'b1;
    run_to_done(0, 1'b0, n, hi);
    halt0 = 1'b0;
    chk("t1.latency",    32'(n),            32'd19);
    chk("t1.pass",       32'(pass_w[0]),    32'd1);
    chk("t1.fail_count", 32'(fcnt_w[0]),    32'd0);
    chk("t1.run_cycles", runc_w[0],         32'd10);
    chk("t1.rst_hi",     32'(hi),           32'd2);

    regs[0][2] = 32'd21;
    regs[0][3] = 32'd31;
    run_to_done(0, 1'b0, n, hi);
    chk("t2.pass",       32'(pass_w[0]),    32'd0);
    chk("t2.fail_count", 32'(fcnt_w[0]),    32'd2);
    chk("t2.ff_idx",     32'(ffi_w[0]),     32'd1);
    chk("t2.ff_data",    ffd_w[0],          32'd21);

    run_to_done(1, 1'b0, n, hi);
    chk("t4.latency",    32'(n),            32'd13);
    chk("t4.timeout",    32'(to_w[1]),      32'd1);
    chk("t4.pass",       32'(pass_w[1]),    32'd0);
    chk("t4.dbg_raddr",  32'(raddr_w[1]),   32'd0);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    halt1 = 1'b1;
    hpc   = pc;
    tick();
    halt1 = 1'b0;
    wait_done(1, 7, n, hi);
    chk("t3.run_cycles", runc_w[1],         32'd4);
    chk("t3.final_pc",   fpc_w[1],          hpc);
    chk("t3.timeout",    32'(to_w[1]),      32'd0);
    chk("t3.pass",       32'(pass_w[1]),    32'd1);
    chk("t3.latency",    32'(n),            32'd13);

    regs[0][2] = 32'd20;
    regs[0][3] = 32'd30;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("t5.cpu_rst",    32'(cpu_rst_w[0]), 32'd1);
    chk("t5.busy",       32'(busy_w[0]),    32'd0);
    chk("t5.run_cycles", runc_w[0],         32'd0);
    chk("t5.ff_idx",     32'(ffi_w[0]),     32'd7);
    tick();
    rst = 1'b0;
    tick();
    run_to_done(0, 1'b0, n, hi);
    chk("t5.latency",    32'(n),            32'd19);
    chk("t5.pass",       32'(pass_w[0]),    32'd1);

    run_to_done(0, 1'b1, n, hi);
    chk("t6.latency",    32'(n),            32'd19);
    repeat (3) tick();
    chk("t6.done_hold",  32'(done_w[0]),    32'd1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t6.done_clr",   32'(done_w[0]),    32'd0);
    chk("t6.busy",       32'(busy_w[0]),    32'd1);
    wait_done(0, 1, n, hi);
    chk("t6.relatency",  32'(n),            32'd19);
    chk("t6.rst_hi",     32'(hi + 1),       32'd2);
    chk("t6.pass",       32'(pass_w[0]),    32'd1);
    chk("t6.run_cycles", runc_w[0],         32'd10);

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
